// File: rtl/fir_da_pkg.sv
// Shared types and helpers for the bit-serial DA FIR sequencer.
// Provides the FSM state enum, accumulator width and saturating truncation.
package fir_da_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } state_t;

   function automatic int acc_width(int ww, int dw);
      return ww + dw + 1;
   endfunction

   // Clamp a sign-extended value into a signed ow-bit range.
   function automatic logic signed [63:0] sat_trunc(
      logic signed [63:0] acc,
      int ow
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (acc > hi) return hi;
      if (acc < lo) return lo;
      return acc;
   endfunction

endpackage

// File: rtl/fir_da_tap_line.sv
// TAPS x DATA_WIDTH sample delay line with bit-slice readout.
// Ports: clk, rst (async high), shift_en, din, sel (bit index j), slice (bit j of every tap).
module fir_da_tap_line #(
   parameter int TAPS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int SEL_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [SEL_W-1:0]      sel,
   output logic [TAPS-1:0]       slice
);

   logic [DATA_WIDTH-1:0] tap_q [TAPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
      end else if (shift_en) begin
         tap_q[0] <= din;
         for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
      end
   end

   always_comb begin
      slice = '0;
      for (int k = 0; k < TAPS; k++) slice[k] = tap_q[k][sel];
   end

endmodule

// File: rtl/fir_da_controller.sv
// Bit-serial DA FIR sequencer for an offset-binary half-table ROM.
// Ports: clk, rst (async high), in_valid/in_ready/in_data sample input,
// out_valid/out_ready/out_data result, rom_address/rom_en/rom_data ROM side, busy.
// Macro FIR_DA_SAT_EN: saturate the result to OUT_WIDTH instead of wrapping.
module fir_da_controller
   import fir_da_pkg::*;
#(
   parameter int TAPS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int WORD_WIDTH = 16,
   parameter int OUT_WIDTH  = 32,
   parameter logic signed [WORD_WIDTH+DATA_WIDTH:0] OFFSET = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic [TAPS-1:0]       rom_address,
   output logic                  rom_en,
   input  logic [WORD_WIDTH-1:0] rom_data,
   output logic                  busy
);

   localparam int ACC_WIDTH = acc_width(WORD_WIDTH, DATA_WIDTH);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [TAPS-1:0] slice;
   logic accept, last;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_next;
   logic signed [ACC_WIDTH-1:0] t_ext, term, res_sum;
   logic signed [63:0] res_wide, res_fmt;
   logic unused_ok;

   assign accept = in_valid & in_ready;
   assign last   = (cnt_q == LAST);

   fir_da_tap_line #(
      .TAPS       (TAPS),
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_W      (CNT_W)
   ) u_taps (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .din      (in_data),
      .sel      (cnt_q),
      .slice    (slice)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (last) state_d = OUT;
         OUT:     if (out_ready) state_d = accept ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = ~rst & ((state_q == IDLE) |
                            ((state_q == OUT) & out_ready));
      out_valid   = (state_q == OUT);
      busy        = (state_q != IDLE);
      rom_en      = (state_q == CALC);
      rom_address = (state_q == CALC) ? slice : '0;
   end

   // Half table stores Q(a) for a[0]=0; Q(~a) = -Q(a) covers the rest.
   // The sign-bit slice carries weight -2^j, hence the subtraction.
   always_comb begin
      t_ext = ACC_WIDTH'(signed'(rom_data));
      if (rom_address[0]) t_ext = -t_ext;
      term     = t_ext <<< cnt_q;
      acc_next = last ? (acc_q - term) : (acc_q + term);
      res_sum  = acc_next + OFFSET;
      res_wide = 64'(res_sum);
`ifdef FIR_DA_SAT_EN
      res_fmt  = sat_trunc(res_wide, OUT_WIDTH);
`else
      res_fmt  = res_wide;
`endif
   end

   // Upper bits of the 64-bit staging value are dropped on purpose.
   assign unused_ok = &{1'b0, res_fmt};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         out_data <= '0;
      end else if (accept) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (state_q == CALC) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q + 1'b1;
         if (last) out_data <= res_fmt[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_fir_da_controller.sv
// Self-checking bench for fir_da_controller with h={1,2,3}, OFFSET=-3.
// Two instances (OUT_WIDTH 16 and 6) run in lockstep against a direct-form FIR model.
module tb_fir_da_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [3:0] in_data = '0;

   logic in_ready, out_valid, rom_en, busy;
   logic [15:0] out_data;
   logic [2:0] rom_address;
   logic [7:0] rom_data;

   logic in_ready2, out_valid2, rom_en2, busy2;
   logic [5:0] out_data2;
   logic [2:0] rom_address2;
   logic [7:0] rom_data2;

   int checks = 0;
   int failures = 0;
   int hist[$];

   always #5 clk = ~clk;

   // Offset-binary half table for h={1,2,3}: mem={-3,-1,0,2}.
   function automatic logic [7:0] rom_word(logic [2:0] a);
      logic [1:0] i;
      i = a[0] ? ~a[2:1] : a[2:1];
      case (i)
         2'd0:    return 8'hFD;
         2'd1:    return 8'hFF;
         2'd2:    return 8'h00;
         default: return 8'h02;
      endcase
   endfunction

   assign rom_data  = rom_word(rom_address);
   assign rom_data2 = rom_word(rom_address2);

   fir_da_controller #(
      .TAPS(3), .DATA_WIDTH(4), .WORD_WIDTH(8),
      .OUT_WIDTH(16), .OFFSET(-13'sd3)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rom_address(rom_address), .rom_en(rom_en), .rom_data(rom_data),
      .busy(busy)
   );

   fir_da_controller #(
      .TAPS(3), .DATA_WIDTH(4), .WORD_WIDTH(8),
      .OUT_WIDTH(6), .OFFSET(-13'sd3)
   ) dut6 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .rom_address(rom_address2), .rom_en(rom_en2), .rom_data(rom_data2),
      .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] fmt16(int y);
`ifdef FIR_DA_SAT_EN
      if (y > 32767) return 16'h7FFF;
      if (y < -32768) return 16'h8000;
`endif
      return y[15:0];
   endfunction

   function automatic logic [5:0] fmt6(int y);
`ifdef FIR_DA_SAT_EN
      if (y > 31) return 6'h1F;
      if (y < -32) return 6'h20;
`endif
      return y[5:0];
   endfunction

   // Direct-form y[n] = 1*x[n] + 2*x[n-1] + 3*x[n-2].
   function automatic int model_push(int x);
      hist.push_front(x);
      void'(hist.pop_back());
      return hist[0] + 2 * hist[1] + 3 * hist[2];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_rom_addr", rom_address, 0);
      tick();
      rst = 1'b0;
      hist = '{0, 0, 0};
      #1;
   endtask

   task automatic run_sample(input int x, input int hold, input bit mid);
      int n;
      int y;
      logic [2:0] ea;
      logic [15:0] held;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("rdy_wait", n < 20, 1);
      in_valid = 1'b1;
      in_data = x[3:0];
      y = model_push(x);
      tick();
      in_valid = 1'b0;
      check("calc_busy", busy, 1);
      check("calc_in_ready", in_ready, 0);
      for (int j = 0; j < 4; j++) begin
         ea = {hist[2][j], hist[1][j], hist[0][j]};
         check("rom_addr", rom_address, ea);
         check("rom_en", rom_en, 1);
         check("calc_out_valid", out_valid, 0);
         if (mid && j == 0) check("mid_rom_data", rom_data, 8'd2);
         tick();
      end
      check("out_valid", out_valid, 1);
      check("out_data16", out_data, fmt16(y));
      check("out_data6", out_data2, fmt6(y));
      held = out_data;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = 4'($urandom_range(0, 15));
         tick();
         check("hold_data", out_data, held);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_busy", busy, 0);
   endtask

   task automatic back_to_back(input int num);
      int acc_cyc, cyc, accepts, pops, y;
      bit acc_now;
      int expq[$];
      acc_cyc = 0;
      cyc = 0;
      accepts = 0;
      pops = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 4'($urandom_range(0, 15));
      while (pops < num && cyc < 100) begin
         if (accepts == num) in_valid = 1'b0;
         acc_now = in_valid && in_ready;
         if (accepts > 0) check("b2b_in_ready", in_ready, out_valid);
         if (out_valid) begin
            y = expq.pop_front();
            check("b2b_lat", cyc - acc_cyc, 5);
            check("b2b_data16", out_data, fmt16(y));
            check("b2b_data6", out_data2, fmt6(y));
            pops++;
         end
         if (acc_now) begin
            expq.push_back(model_push(int'($signed(in_data))));
            acc_cyc = cyc;
            accepts++;
         end
         tick();
         cyc++;
         if (acc_now) in_data = 4'($urandom_range(0, 15));
      end
      check("b2b_done", pops, num);
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // Impulse
      run_sample(1, 0, 1'b1);
      run_sample(0, 0, 1'b0);
      run_sample(0, 0, 1'b0);
      run_sample(0, 0, 1'b0);

      // Sign bit, then constant 7
      do_reset();
      run_sample(-8, 0, 1'b0);
      run_sample(0, 0, 1'b0);
      run_sample(0, 0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) run_sample(7, 0, 1'b0);

      // Back-to-back
      do_reset();
      back_to_back(5);

      // Backpressure with ignored in_valid pulses
      run_sample(3, 10, 1'b0);
      run_sample(-5, 0, 1'b0);

      // Reset during CALC at j=2
      in_valid = 1'b1;
      in_data = 4'd5;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("abort_pre_j2_addr", rom_address[0], 1'b1);
      rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_rom_en", rom_en, 0);
      check("abort_in_ready", in_ready, 0);
      tick();
      tick();
      rst = 1'b0;
      hist = '{0, 0, 0};
      tick();
      check("abort_no_out", out_valid, 0);
      run_sample(1, 0, 1'b1);
      run_sample(0, 0, 1'b0);
      run_sample(0, 0, 1'b0);
      run_sample(0, 0, 1'b0);

      // Narrow output: constant -8 reaches -48
      do_reset();
      for (int i = 0; i < 4; i++) run_sample(-8, 0, 1'b0);

      // Random samples with random hold
      for (int i = 0; i < 16; i++)
         run_sample(int'($urandom_range(0, 15)) - 8,
                    int'($urandom_range(0, 3)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
